// File: rtl/fir_sample_feeder_if.sv
// Valid/ready stream bundle used for both the sample input and the result output
// of the FIR sample feeder.
interface fir_sample_feeder_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/fir_sample_feeder.sv
// Streaming front-end for the FIR datapath: buffers samples in a FIFO, strobes each one
// into the datapath (sample then compute), and returns the result on a stream port.
module fir_sample_feeder #(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    fir_sample_feeder_if.slave            s_axis,
    fir_sample_feeder_if.master           m_axis,
    input  logic                          coefficient_loading_complete,
    output logic [DATA_WIDTH-1:0]         x_data,
    output logic                          x_data_valid,
    output logic                          compute,
    input  logic [DATA_WIDTH-1:0]         output_data,
    input  logic                          output_data_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_COMPUTE = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_OUT     = 3'd4;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;

    logic [2:0]            state_reg;
    logic [TO_W-1:0]       timeout_cnt_reg;
    logic [DATA_WIDTH-1:0] x_data_reg;
    logic                  x_data_valid_reg;
    logic                  compute_reg;
    logic [DATA_WIDTH-1:0] m_tdata_reg;
    logic                  m_tvalid_reg;
    logic                  timeout_err_reg;

    logic s_ready;
    logic push;
    logic pop;
    logic launch;
    logic timeout_hit;

    assign s_ready = (count_reg != FIFO_FULL);
    assign push    = s_axis.tvalid && s_ready;
    assign pop     = (state_reg == ST_LOAD);
    assign launch  = enable && coefficient_loading_complete &&
                     (count_reg != '0) && !m_tvalid_reg;
    // Fires on the WAIT cycle whose increment would bring the counter to TIMEOUT_CYCLES-1.
    assign timeout_hit = ((timeout_cnt_reg + 1'b1) == TO_LIMIT);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= s_axis.tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            timeout_cnt_reg  <= '0;
            x_data_reg       <= '0;
            x_data_valid_reg <= 1'b0;
            compute_reg      <= 1'b0;
            m_tdata_reg      <= '0;
            m_tvalid_reg     <= 1'b0;
            timeout_err_reg  <= 1'b0;
        end else begin
            x_data_valid_reg <= 1'b0;
            compute_reg      <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // Head is read on the launch edge so it is on x_data throughout LOAD.
                    if (launch) begin
                        x_data_reg       <= fifo_mem[rd_ptr_reg];
                        x_data_valid_reg <= 1'b1;
                        state_reg        <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    compute_reg <= 1'b1;
                    state_reg   <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    timeout_cnt_reg <= '0;
                    state_reg       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (output_data_valid) begin
                        m_tdata_reg  <= output_data;
                        m_tvalid_reg <= 1'b1;
                        state_reg    <= ST_OUT;
                    end else if (timeout_hit) begin
                        timeout_err_reg <= 1'b1;
                        state_reg       <= ST_IDLE;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (m_axis.tready) begin
                        m_tvalid_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = m_tdata_reg;
    assign m_axis.tvalid = m_tvalid_reg;
    assign x_data        = x_data_reg;
    assign x_data_valid  = x_data_valid_reg;
    assign compute       = compute_reg;
    assign fifo_count    = count_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign timeout_err   = timeout_err_reg;

endmodule
